// File: rtl/alarm_ctrl.sv
// Alarm-time/enable owner for the alarm comparator: button editing, arm/disarm,
// and ring handling (gated buzzer tone, stop, snooze, auto-timeout).
module alarm_ctrl #(
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_TIMEOUT = 60,
    parameter int TONE_DIV     = 25000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_arm,
    input  logic       btn_stop,
    input  logic       btn_snooze,
    input  logic       alarm_sound,
    output logic       isalram,
    output logic [5:0] amin,
    output logic [5:0] asec,
    output logic [1:0] mode,
    output logic       buzzer,
    output logic       snoozing
);
    localparam int CW = $clog2(RING_TIMEOUT + 1);
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [CW-1:0] RC_LAST   = CW'(RING_TIMEOUT - 1);
    localparam logic [CW-1:0] RC_MAX    = CW'(RING_TIMEOUT);
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_EDIT_MIN, S_EDIT_SEC, S_RING, S_CLEAR} state_t;

    state_t        state_q;
    logic          armed_q, isalram_q, buzzer_q, snoozing_q;
    logic          beep_q, tone_q;
    logic [5:0]    amin_q, asec_q;
    logic [1:0]    mode_q;
    logic [CW-1:0] ring_cnt_q;
    logic [TW-1:0] tone_cnt_q;

    logic [5:0] amin_inc, asec_inc, amin_snz_d;
    logic [6:0] snz_sum, snz_adj;
    logic       timeout;

    assign amin_inc   = (amin_q == 6'd59) ? 6'd0 : amin_q + 6'd1;
    assign asec_inc   = (asec_q == 6'd59) ? 6'd0 : asec_q + 6'd1;
    // amin <= 59 and SNOOZE_MIN <= 59, so one subtract of 60 is enough
    assign snz_sum    = {1'b0, amin_q} + 7'(SNOOZE_MIN);
    assign snz_adj    = (snz_sum >= 7'd60) ? snz_sum - 7'd60 : snz_sum;
    assign amin_snz_d = snz_adj[5:0];
    assign timeout    = tick_1hz && (ring_cnt_q == RC_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            isalram_q  <= 1'b0;
            buzzer_q   <= 1'b0;
            snoozing_q <= 1'b0;
            beep_q     <= 1'b0;
            tone_q     <= 1'b0;
            amin_q     <= '0;
            asec_q     <= '0;
            mode_q     <= 2'd0;
            ring_cnt_q <= '0;
            tone_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (alarm_sound && armed_q) begin
                        state_q    <= S_RING;
                        mode_q     <= 2'd3;
                        isalram_q  <= 1'b1;
                        buzzer_q   <= 1'b0;
                        ring_cnt_q <= '0;
                        beep_q     <= 1'b1;
                        tone_cnt_q <= '0;
                        tone_q     <= 1'b0;
                        snoozing_q <= 1'b0;
                    end else if (btn_mode) begin
                        state_q    <= S_EDIT_MIN;
                        mode_q     <= 2'd1;
                        isalram_q  <= 1'b0;
                        snoozing_q <= 1'b0;
                    end else if (btn_arm) begin
                        armed_q    <= ~armed_q;
                        isalram_q  <= ~armed_q;
                        snoozing_q <= 1'b0;
                    end else begin
                        isalram_q  <= armed_q;
                    end
                end
                S_EDIT_MIN: begin
                    isalram_q <= 1'b0;
                    if (btn_mode) begin
                        state_q <= S_EDIT_SEC;
                        mode_q  <= 2'd2;
                    end else if (btn_inc) begin
                        amin_q  <= amin_inc;
                    end
                end
                S_EDIT_SEC: begin
                    if (btn_mode) begin
                        state_q   <= S_IDLE;
                        mode_q    <= 2'd0;
                        isalram_q <= armed_q;
                    end else begin
                        isalram_q <= 1'b0;
                        if (btn_inc) asec_q <= asec_inc;
                    end
                end
                S_RING: begin
                    if (tone_cnt_q == TONE_LAST) begin
                        tone_cnt_q <= '0;
                        tone_q     <= ~tone_q;
                    end else begin
                        tone_cnt_q <= tone_cnt_q + TW'(1);
                    end
                    if (tick_1hz) begin
                        beep_q <= ~beep_q;
                        if (ring_cnt_q != RC_MAX) ring_cnt_q <= ring_cnt_q + CW'(1);
                    end
                    if (btn_stop || (!btn_snooze && timeout)) begin
                        armed_q   <= 1'b0;
                        state_q   <= S_CLEAR;
                        mode_q    <= 2'd0;
                        isalram_q <= 1'b0;
                        buzzer_q  <= 1'b0;
                    end else if (btn_snooze) begin
                        amin_q     <= amin_snz_d;
                        snoozing_q <= 1'b1;
                        state_q    <= S_CLEAR;
                        mode_q     <= 2'd0;
                        isalram_q  <= 1'b0;
                        buzzer_q   <= 1'b0;
                    end else if (!alarm_sound) begin
                        state_q   <= S_IDLE;
                        mode_q    <= 2'd0;
                        isalram_q <= armed_q;
                        buzzer_q  <= 1'b0;
                    end else begin
                        isalram_q <= armed_q;
                        buzzer_q  <= tone_q & beep_q;
                    end
                end
                S_CLEAR: begin
                    // comparator has now seen isalram=0 and dropped its latch
                    state_q   <= S_IDLE;
                    mode_q    <= 2'd0;
                    isalram_q <= armed_q;
                    buzzer_q  <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    mode_q    <= 2'd0;
                    isalram_q <= 1'b0;
                    buzzer_q  <= 1'b0;
                end
            endcase
        end
    end

    assign isalram  = isalram_q;
    assign amin     = amin_q;
    assign asec     = asec_q;
    assign mode     = mode_q;
    assign buzzer   = buzzer_q;
    assign snoozing = snoozing_q;
endmodule
